// File: rtl/micro_sequencer.sv
// micro_sequencer: next-address controller for the microprogrammed CPU.
// Picks the next micro-PC from the current micro-word's sequencing field,
// raises the IR-load strobe at fetch, handles memory waits with timeout,
// halts/restarts, and counts retired instructions.
module micro_sequencer #(
    parameter int unsigned           UADDR_W     = 8,
    parameter logic [UADDR_W-1:0]    FETCH_ADDR  = UADDR_W'(8'h00),
    parameter logic [UADDR_W-1:0]    TRAP_ADDR   = UADDR_W'(8'hF0),
    parameter int unsigned           MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         opcode,
    input  logic [2:0]         uc_cond,
    input  logic [UADDR_W-1:0] uc_next,
    input  logic               flag_z,
    input  logic               flag_n,
    input  logic               mem_ready,
    input  logic               run,
    output logic [UADDR_W-1:0] upc,
    output logic               ir_load,
    output logic               stall,
    output logic               halted,
    output logic               mem_err,
    output logic [15:0]        instr_count
);

    localparam int unsigned WAIT_W   = 8;
    localparam int unsigned CNT_W    = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [3:0]  OP_ILLEGAL = 4'b1111;

    localparam logic [2:0] UC_SEQ    = 3'b000;
    localparam logic [2:0] UC_JMP    = 3'b001;
    localparam logic [2:0] UC_BZ     = 3'b010;
    localparam logic [2:0] UC_BN     = 3'b011;
    localparam logic [2:0] UC_DISP   = 3'b100;
    localparam logic [2:0] UC_END    = 3'b101;
    localparam logic [2:0] UC_MWAIT  = 3'b110;
    localparam logic [2:0] UC_HALT   = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [UADDR_W-1:0]  upc_q, upc_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic [CNT_W-1:0]    instr_count_q, instr_count_d;
    logic [UADDR_W-1:0]  upc_inc;

    assign upc_inc = upc_q + UADDR_W'(1);

    // Next-state selection: sequencing field decode in RUN, restart in HALT.
    always_comb begin
        state_d       = state_q;
        upc_d         = upc_q;
        wait_cnt_d    = '0;
        mem_err_d     = mem_err_q;
        instr_count_d = instr_count_q;
        unique case (state_q)
            ST_RUN: begin
                unique case (uc_cond)
                    UC_SEQ:  upc_d = upc_inc;
                    UC_JMP:  upc_d = uc_next;
                    UC_BZ:   upc_d = flag_z ? uc_next : upc_inc;
                    UC_BN:   upc_d = flag_n ? uc_next : upc_inc;
                    UC_DISP: upc_d = (opcode == OP_ILLEGAL) ? TRAP_ADDR
                                                            : UADDR_W'({opcode, 4'b0000});
                    UC_END: begin
                        upc_d         = FETCH_ADDR;
                        instr_count_d = instr_count_q + CNT_W'(1);
                    end
                    UC_MWAIT: begin
                        if (mem_ready) begin
                            upc_d = upc_inc;
                        end else if (wait_cnt_q == WAIT_LAST) begin
                            upc_d     = TRAP_ADDR;
                            mem_err_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end
                    UC_HALT: state_d = ST_HALT;
                    default: upc_d = upc_q;
                endcase
            end
            ST_HALT: begin
                if (run) begin
                    upc_d   = FETCH_ADDR;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            upc_q         <= FETCH_ADDR;
            wait_cnt_q    <= '0;
            mem_err_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            upc_q         <= upc_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign upc         = upc_q;
    assign halted      = (state_q == ST_HALT);
    assign mem_err     = mem_err_q;
    assign instr_count = instr_count_q;
    assign ir_load     = (state_q == ST_RUN) && (upc_q == FETCH_ADDR);
    assign stall       = (state_q == ST_RUN) && (uc_cond == UC_MWAIT) && !mem_ready;

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Next-address controller for the microprogrammed CPU; drives the micro-PC into the micro-ROM whose 33-bit word feeds the instruction mux.
- Selects the next micro-address each cycle: sequential step, conditional branch on ALU flags, opcode dispatch, return-to-fetch, memory wait with timeout, and halt.
- Also produces the IR-load strobe and counts retired instructions.

Parameters:
- UADDR_W, 8, micro-address width.
- FETCH_ADDR, 8'h00, micro-address of the fetch routine.
- TRAP_ADDR, 8'hF0, micro-address jumped to on an illegal opcode or a memory timeout.
- MEM_TIMEOUT, 15, maximum consecutive wait cycles before a trap (range 1..255).

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-high.
- opcode, in, 4, instruction[21:18] from the IR.
- uc_cond, in, 3, sequencing-control field of the current micro-word.
- uc_next, in, UADDR_W, branch-target field of the current micro-word.
- flag_z, in, 1, ALU zero flag.
- flag_n, in, 1, ALU negative flag.
- mem_ready, in, 1, memory access complete.
- run, in, 1, restart request, honoured only in HALT.
- upc, out, UADDR_W, registered micro-PC, i.e. the micro-ROM address.
- ir_load, out, 1, combinational: state==RUN and upc==FETCH_ADDR.
- stall, out, 1, combinational: state==RUN, uc_cond==110 and mem_ready==0.
- halted, out, 1, registered: state==HALT.
- mem_err, out, 1, registered, sticky memory-timeout flag.
- instr_count, out, 16, registered count of retired instructions.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-wait or in HALT):
  - upc=FETCH_ADDR, state=RUN, wait_cnt=0.
  - halted=0, mem_err=0, instr_count=0.
  - Outputs are valid in the same cycle.
- States: RUN and HALT.
- Each rising edge in RUN, the next upc is chosen by uc_cond (upc+1 is modulo 2^UADDR_W, so 8'hFF+1 wraps to 8'h00):
  - 000: upc+1.
  - 001: uc_next.
  - 010: flag_z ? uc_next : upc+1.
  - 011: flag_n ? uc_next : upc+1.
  - 100 (dispatch): {opcode,4'b0000}, giving 16 micro-words per opcode. Opcode 4'b1111 is illegal and goes to TRAP_ADDR instead.
  - 101 (end of instruction): FETCH_ADDR, and instr_count+1 (16-bit wrap, FFFF to 0000).
  - 110 (memory wait):
    - If mem_ready=1: upc+1, wait_cnt cleared.
    - Else if wait_cnt==MEM_TIMEOUT-1: upc=TRAP_ADDR, mem_err set, wait_cnt cleared.
    - Else: upc holds, wait_cnt+1.
  - 111: upc holds, state goes to HALT.
- wait_cnt is an 8-bit register. It is cleared on any edge where uc_cond!=110.
- With MEM_TIMEOUT=15, the trap is taken on the 15th consecutive not-ready edge.
- If mem_ready rises on the timeout edge, ready wins: no trap, no error.
- HALT:
  - upc frozen, instr_count frozen, stall=0, ir_load=0. uc_cond, flags and mem_ready are ignored.
  - run=1 at an edge: upc=FETCH_ADDR, state returns to RUN.
  - run is ignored while in RUN.
- mem_err clears only on reset. A trap does not stop sequencing; the microcode at TRAP_ADDR handles it.
- Flags and opcode are sampled at the same edge as uc_cond; no internal pipelining. Branch latency is 1 cycle: the target appears on upc the cycle after the branch micro-word.

Test Plan:
- Sequential and wrap: release reset; uc_cond=000 for 3 edges -> upc 00,01,02,03, ir_load=1 only at 00. Force upc=FF with 000 -> next upc=00.
- Branches: upc=10, uc_cond=010, uc_next=40:
  - flag_z=1 -> upc=40.
  - flag_z=0 -> upc=11.
  - Same pattern for 011 with flag_n.
- Dispatch and retire:
  - opcode=0110, uc_cond=100 -> upc=60.
  - opcode=1111 -> upc=F0.
  - uc_cond=101 -> upc=00, instr_count increments by 1; from FFFF it wraps to 0000.
- Memory wait: uc_cond=110 at upc=22, mem_ready low 3 edges then high -> stall=1 for 3 cycles, upc holds 22, then 23; mem_err=0.
- Timeout:
  - mem_ready held low -> upc=F0 on the 15th edge, mem_err=1 and stays 1 afterwards.
  - Variant: mem_ready rises on the 15th edge -> upc=23, mem_err=0.
- Halt, run, reset:
  - uc_cond=111 at upc=35 -> halted=1, upc stays 35 for 10 cycles despite input changes.
  - run=1 -> upc=00, halted=0.
  - Assert reset asynchronously mid-wait (between edges) -> upc=00, mem_err=0, instr_count=0 immediately.
